alu: RTL and testbench
======================

# alu

4-bit registered arithmetic/logic unit with a 5-bit result, selected by a 5-bit opcode. Computes arithmetic, shift/rotate, bitwise-logic and compare functions of two 4-bit operands plus a carry-in, and registers the result on the clock. It is the datapath execution stage: operands and opcode come from the decode/register stage, and the result (including carry/borrow) goes to writeback.

## Interface
- No parameters; widths fixed (operands 4 bits, result 5 bits, opcode 5 bits).
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- out  output  5  registered result; out[4] is carry/borrow/shifted-out bit, out[3:0] is data.
- a1  input  4  operand A, unsigned.
- b1  input  4  operand B, unsigned.
- switch  input  5  opcode; switch[4]=0 selects the arithmetic/shift group, 1 selects the logic/compare group.
- cary  input  1  carry-in / borrow-in / shift-in bit.
- Port declaration order: clk, rst_n, out, a1, b1, switch, cary.

## Operation
- Arithmetic group: widths are zero-extended to 5 bits; the result is taken modulo 32.
- 0: A+B+cin. 1: A−B−cin (out[4]=1 on borrow). 2: A+1. 3: A−1. 4: B+1. 5: B−1. 6: A+cin. 7: −A (two's complement, 5-bit).
- 8: shift left, out={A[3],A[2:0],cin}. 9: shift right, out={A[0],cin,A[3:1]}. 10: rotate left, out={A[3],A[2:0],A[3]}. 11: rotate right, out={A[0],A[0],A[3:1]}.
- 12: pass A, out={0,A}. 13: pass B. 14: A+B, ignoring cin. 15: A−B, ignoring cin.
- Logic group: out[4]=0; cin is ignored.
- 16: A&B. 17: A|B. 18: A^B. 19: ~A. 20: ~(A&B). 21: ~(A|B). 22: ~(A^B). 23: ~B.
- 24: A&~B. 25: A|~B. 26: ~A&B. 27: ~A|B.
- 28: compare, out={0,0,A<B,A>B,A==B}, unsigned. 29: min(A,B). 30: max(A,B). 31: zero.
- The result is a pure function of the current a1, b1, switch and cary; the ALU keeps no internal state besides the output register.
- An X or undefined opcode never occurs: all 32 codes are defined.

## Timing
- Inputs are sampled at each rising clk edge; out shows that result from the same edge until the next one. Latency is 1 cycle; a new operation can start every cycle.
- rst_n low forces out=5'b00000 immediately, independent of clk, and holds it while low. The first operation is sampled at the first rising edge after rst_n deasserts.
- Reset asserted mid-stream discards the in-flight result; there is no pending state to recover.
- No handshake. Inputs must meet setup/hold around the rising edge.

## Test plan
- Reset: rst_n=0 asynchronously while out is nonzero -> out=0 with no clock edge; after release, A=6,B=5,cin=0,op 0 -> out=5'b01011 one edge later.
- Add/carry: A=7,B=5,cin=1,op 0 -> 13. A=15,B=15,cin=1,op 0 -> 5'b11111. Op 2 with A=7 -> 8. Op 3 with A=7 -> 6.
- Subtract/borrow: A=7,B=5,cin=0,op 1 -> 2. A=5,B=7,cin=0,op 1 -> 5'b11110 (borrow set). A=0,op 3 -> 5'b11111.
- Logic: A=7,B=5: op 16 -> 5. Op 20 -> 5'b01010. Op 24 -> 2. Op 18 -> 2. Op 19 -> 8. out[4]=0 throughout.
- Compare: A=7,B=5,cin=1,op 28 -> 5'b00010. A=B=9 -> 5'b00001. A=3,B=9 -> 5'b00100. Op 29/30 with A=3,B=9 -> 3/9.
- Shifts: A=4'b1001,cin=1: op 8 -> 5'b10011. Op 9 -> 5'b11100. Op 10 -> 5'b10011. Op 11 -> 5'b11100. Back-to-back opcode changes every cycle each produce the correct value exactly one edge later.

Source files
------------

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : 4-bit registered ALU, 5-bit result, 32 opcodes. The arithmetic
//            and shift group returns carry/borrow/shift-out in out[4]. The
//            logic and compare group forces out[4] to 0. Latency is one cycle.
// Revision : 1.0  initial release
// ============================================================================
module alu (
    input  logic       clk,
    input  logic       rst_n,
    output logic [4:0] out,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    input  logic [4:0] switch,
    input  logic       cary
);

    // Operands zero-extended to 5 bits so that arithmetic wraps modulo 32
    // and the carry or borrow lands naturally in bit 4.
    logic [4:0] a_ext;
    logic [4:0] b_ext;
    logic [4:0] c_ext;
    logic [4:0] out_d;
    logic [4:0] out_q;

    assign a_ext = {1'b0, a1};
    assign b_ext = {1'b0, b1};
    assign c_ext = {4'b0000, cary};

    // Next-state result: a pure function of the current operands, opcode and carry-in
    always_comb begin
        out_d = 5'b00000;
        case (switch)
            // Arithmetic group
            5'd0:  out_d = a_ext + b_ext + c_ext;
            5'd1:  out_d = a_ext - b_ext - c_ext;
            5'd2:  out_d = a_ext + 5'd1;
            5'd3:  out_d = a_ext - 5'd1;
            5'd4:  out_d = b_ext + 5'd1;
            5'd5:  out_d = b_ext - 5'd1;
            5'd6:  out_d = a_ext + c_ext;
            5'd7:  out_d = 5'd0 - a_ext;
            // Shift/rotate: out[4] receives the bit shifted out of A
            5'd8:  out_d = {a1[3], a1[2:0], cary};
            5'd9:  out_d = {a1[0], cary, a1[3:1]};
            5'd10: out_d = {a1[3], a1[2:0], a1[3]};
            5'd11: out_d = {a1[0], a1[0], a1[3:1]};
            5'd12: out_d = a_ext;
            5'd13: out_d = b_ext;
            5'd14: out_d = a_ext + b_ext;
            5'd15: out_d = a_ext - b_ext;
            // Logic group: bit 4 is always zero
            5'd16: out_d = {1'b0, a1 & b1};
            5'd17: out_d = {1'b0, a1 | b1};
            5'd18: out_d = {1'b0, a1 ^ b1};
            5'd19: out_d = {1'b0, ~a1};
            5'd20: out_d = {1'b0, ~(a1 & b1)};
            5'd21: out_d = {1'b0, ~(a1 | b1)};
            5'd22: out_d = {1'b0, ~(a1 ^ b1)};
            5'd23: out_d = {1'b0, ~b1};
            5'd24: out_d = {1'b0, a1 & ~b1};
            5'd25: out_d = {1'b0, a1 | ~b1};
            5'd26: out_d = {1'b0, ~a1 & b1};
            5'd27: out_d = {1'b0, ~a1 | b1};
            // Unsigned compare flags: {lt, gt, eq} in the low three bits
            5'd28: out_d = {2'b00, (a1 < b1), (a1 > b1), (a1 == b1)};
            5'd29: out_d = (a1 < b1) ? a_ext : b_ext;
            5'd30: out_d = (a1 > b1) ? a_ext : b_ext;
            5'd31: out_d = 5'b00000;
            default: out_d = 5'b00000;
        endcase
    end

    // Output register; reset clears it immediately, independent of clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 5'b00000;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Brief    : Self-checking bench for alu. It runs directed cases, back-to-back
//            opcode changes and randomized operations, and checks each result
//            against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [4:0] out;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [4:0] switch;
    logic       cary;

    int checks = 0;
    int errors = 0;

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .out    (out),
        .a1     (a1),
        .b1     (b1),
        .switch (switch),
        .cary   (cary)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model using plain integer arithmetic on the operand values
    function automatic logic [4:0] model(input int a, input int b, input int op, input int c);
        int r;
        int na;
        int nb;
        na = 15 - a;
        nb = 15 - b;
        case (op)
            0:  r = a + b + c;
            1:  r = a - b - c + 64;
            2:  r = a + 1;
            3:  r = a - 1 + 32;
            4:  r = b + 1;
            5:  r = b - 1 + 32;
            6:  r = a + c;
            7:  r = 32 - a;
            8:  r = a * 2 + c;
            9:  r = (a % 2) * 16 + c * 8 + a / 2;
            10: r = a * 2 + a / 8;
            11: r = (a % 2) * 24 + a / 2;
            12: r = a;
            13: r = b;
            14: r = a + b;
            15: r = a - b + 32;
            16: r = a & b;
            17: r = a | b;
            18: r = a ^ b;
            19: r = na;
            20: r = 15 - (a & b);
            21: r = 15 - (a | b);
            22: r = 15 - (a ^ b);
            23: r = nb;
            24: r = a & nb;
            25: r = a | nb;
            26: r = na & b;
            27: r = na | b;
            28: r = (a < b) ? 4 : ((a > b) ? 2 : 1);
            29: r = (a < b) ? a : b;
            30: r = (a > b) ? a : b;
            default: r = 0;
        endcase
        return 5'(r % 32);
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply one operation on the falling edge and sample just after the next rising edge
    task automatic drive(input int a, input int b, input int op, input int c);
        @(negedge clk);
        a1     = 4'(a);
        b1     = 4'(b);
        switch = 5'(op);
        cary   = 1'(c);
        @(posedge clk);
        #1;
    endtask

    // Drive, then compare against both a hand-derived constant and the model
    task automatic op_chk(input string tag, input int a, input int b, input int op,
                          input int c, input logic [4:0] exp);
        drive(a, b, op, c);
        check(tag, out, exp);
        check({tag, "_model"}, out, model(a, b, op, c));
    endtask

    initial begin
        rst_n  = 1'b0;
        a1     = 4'd0;
        b1     = 4'd0;
        switch = 5'd0;
        cary   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_init", out, 5'b00000);

        // Asynchronous reset while out is nonzero
        @(negedge clk);
        rst_n = 1'b1;
        op_chk("add_max", 15, 15, 0, 1, 5'b11111);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", out, 5'b00000);
        drive(7, 5, 0, 1);
        check("reset_hold", out, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        op_chk("post_reset", 6, 5, 0, 0, 5'b01011);

        // Add / carry
        op_chk("add_cin", 7, 5, 0, 1, 5'd13);
        op_chk("inc_a", 7, 0, 2, 0, 5'd8);
        op_chk("dec_a", 7, 0, 3, 0, 5'd6);

        // Subtract / borrow
        op_chk("sub", 7, 5, 1, 0, 5'd2);
        op_chk("sub_borrow", 5, 7, 1, 0, 5'b11110);
        op_chk("dec_zero", 0, 3, 3, 0, 5'b11111);

        // Logic
        op_chk("and", 7, 5, 16, 0, 5'd5);
        op_chk("nand", 7, 5, 20, 1, 5'b01010);
        op_chk("andnb", 7, 5, 24, 0, 5'd2);
        op_chk("xor", 7, 5, 18, 1, 5'd2);
        op_chk("nota", 7, 5, 19, 0, 5'd8);

        // Compare / min / max
        op_chk("cmp_gt", 7, 5, 28, 1, 5'b00010);
        op_chk("cmp_eq", 9, 9, 28, 0, 5'b00001);
        op_chk("cmp_lt", 3, 9, 28, 0, 5'b00100);
        op_chk("min", 3, 9, 29, 0, 5'd3);
        op_chk("max", 3, 9, 30, 0, 5'd9);

        // Shifts and rotates, back-to-back opcode changes every cycle
        op_chk("shl", 9, 0, 8, 1, 5'b10011);
        op_chk("shr", 9, 0, 9, 1, 5'b11100);
        op_chk("rol", 9, 0, 10, 1, 5'b10011);
        op_chk("ror", 9, 0, 11, 1, 5'b11100);
        op_chk("neg", 3, 0, 7, 0, 5'd29);
        op_chk("zero", 15, 15, 31, 1, 5'd0);

        // Every opcode once, consecutive cycles, random operands
        for (int op = 0; op < 32; op++) begin
            int a;
            int b;
            int c;
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            c = int'($urandom_range(0, 1));
            drive(a, b, op, c);
            check($sformatf("sweep_op%0d", op), out, model(a, b, op, c));
        end

        // Randomized operations
        for (int i = 0; i < 400; i++) begin
            int a;
            int b;
            int c;
            int op;
            a  = int'($urandom_range(0, 15));
            b  = int'($urandom_range(0, 15));
            c  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 31));
            drive(a, b, op, c);
            check($sformatf("rand%0d_op%0d_a%0d_b%0d_c%0d", i, op, a, b, c),
                  out, model(a, b, op, c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
